// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes and the request bundle shared by the
// arbiter and its clients.
package alu_pkg;

  localparam int unsigned ALU_MAX_W = 64;

  typedef logic [3:0]           alu_op_t;
  typedef logic [ALU_MAX_W-1:0] alu_word_t;

  localparam alu_op_t ALU_AND   = 4'b0000;
  localparam alu_op_t ALU_OR    = 4'b0001;
  localparam alu_op_t ALU_ADD   = 4'b0010;
  localparam alu_op_t ALU_XOR   = 4'b0011;
  localparam alu_op_t ALU_SUB   = 4'b0110;
  localparam alu_op_t ALU_EQUAL = 4'b1000;
  localparam alu_op_t ALU_SLT   = 4'b1100;
  localparam alu_op_t ALU_SLL   = 4'b1101;
  localparam alu_op_t ALU_SRL   = 4'b1110;
  localparam alu_op_t ALU_SRA   = 4'b1111;

  typedef struct packed {
    alu_op_t   op;
    alu_word_t a;
    alu_word_t b;
  } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way grant selection with a last-granted pointer.
// Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority (no pointer).
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] eligible,
  output logic [1:0] win,
  output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_clk;
  assign unused_clk = clk ^ reset_n;
  assign win = {~eligible[0], 1'b1};
`else
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (grant[0])      last_d = 1'b0;
    else if (grant[1]) last_d = 1'b1;
  end

  // Reset as if port 1 went last so port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end

  assign win = {~eligible[0] | ~last_q, ~eligible[1] | last_q};
`endif

  assign grant = eligible & win;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two request ports sharing one external combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ReqValid_0,
  output logic              ReqReady_0,
  input  logic [3:0]        ReqOp_0,
  input  logic [DATA_W-1:0] ReqA_0,
  input  logic [DATA_W-1:0] ReqB_0,
  output logic              RspValid_0,
  input  logic              RspReady_0,
  output logic [DATA_W-1:0] RspData_0,
  input  logic              ReqValid_1,
  output logic              ReqReady_1,
  input  logic [3:0]        ReqOp_1,
  input  logic [DATA_W-1:0] ReqA_1,
  input  logic [DATA_W-1:0] ReqB_1,
  output logic              RspValid_1,
  input  logic              RspReady_1,
  output logic [DATA_W-1:0] RspData_1,
  output logic [3:0]        AluOp,
  output logic [DATA_W-1:0] AluA,
  output logic [DATA_W-1:0] AluB,
  input  logic [DATA_W-1:0] AluResult
);

  alu_req_t          req0, req1, sel;
  logic [1:0]        room, eligible, win, grant;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data0_q, rsp_data0_d;
  logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;

  assign req0 = '{op: ReqOp_0, a: alu_word_t'(ReqA_0), b: alu_word_t'(ReqB_0)};
  assign req1 = '{op: ReqOp_1, a: alu_word_t'(ReqA_1), b: alu_word_t'(ReqB_1)};

  // A slot has room when empty or being drained this cycle.
  assign room = {~rsp_valid_q[1] | RspReady_1,
                 ~rsp_valid_q[0] | RspReady_0};
  assign eligible = {ReqValid_1, ReqValid_0} & room & {2{reset_n}};

  rr_arb2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .eligible (eligible),
    .win      (win),
    .grant    (grant)
  );

  // win[p] looks only at the other port, keeping ready free of own valid.
  assign ReqReady_0 = reset_n & room[0] & win[0];
  assign ReqReady_1 = reset_n & room[1] & win[1];

  assign sel   = grant[1] ? req1 : req0;
  assign AluOp = sel.op;
  assign AluA  = sel.a[DATA_W-1:0];
  assign AluB  = sel.b[DATA_W-1:0];

  if (DATA_W < int'(ALU_MAX_W)) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^{sel.a[ALU_MAX_W-1:DATA_W], sel.b[ALU_MAX_W-1:DATA_W]};
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data0_d = rsp_data0_q;
    rsp_data1_d = rsp_data1_q;
    if (grant[0]) begin
      rsp_valid_d[0] = 1'b1;
      rsp_data0_d    = AluResult;
    end else if (RspReady_0) begin
      rsp_valid_d[0] = 1'b0;
    end
    if (grant[1]) begin
      rsp_valid_d[1] = 1'b1;
      rsp_data1_d    = AluResult;
    end else if (RspReady_1) begin
      rsp_valid_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid_q <= '0;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
    end
  end

  assign RspValid_0 = rsp_valid_q[0];
  assign RspValid_1 = rsp_valid_q[1];
  assign RspData_0  = rsp_data0_q;
  assign RspData_1  = rsp_data1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a
// slot/pointer reference model; honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         rv0, rv1, rr0, rr1;
  logic [3:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ReqReady_0, ReqReady_1, RspValid_0, RspValid_1;
  logic [W-1:0] RspData_0, RspData_1;
  logic [3:0]   AluOp;
  logic [W-1:0] AluA, AluB, AluResult;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  bit           mv[2];
  logic [W-1:0] md[2];
  int           prefer;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .ReqValid_0(rv0), .ReqReady_0(ReqReady_0), .ReqOp_0(op0),
    .ReqA_0(a0), .ReqB_0(b0), .RspValid_0(RspValid_0),
    .RspReady_0(rr0), .RspData_0(RspData_0),
    .ReqValid_1(rv1), .ReqReady_1(ReqReady_1), .ReqOp_1(op1),
    .ReqA_1(a1), .ReqB_1(b1), .RspValid_1(RspValid_1),
    .RspReady_1(rr1), .RspData_1(RspData_1),
    .AluOp(AluOp), .AluA(AluA), .AluB(AluB), .AluResult(AluResult)
  );

  function automatic logic [W-1:0] alu_f(input logic [3:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_ADD:   return a + b;
      ALU_XOR:   return a ^ b;
      ALU_SUB:   return a - b;
      ALU_EQUAL: return (a == b) ? 1 : 0;
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 1 : 0;
      ALU_SLL:   return a << b[4:0];
      ALU_SRL:   return a >> b[4:0];
      ALU_SRA:   return $signed(a) >>> b[4:0];
      default:   return a ^ {b[W-5:0], op};
    endcase
  endfunction

  always_comb AluResult = alu_f(AluOp, AluA, AluB);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mv[0] = 0; mv[1] = 0;
    md[0] = '0; md[1] = '0;
    prefer = 0;
  endtask

  // One clock: check request side before the edge, slots after it.
  task automatic step();
    bit ok[2], el[2], rv[2], rr[2], rdy[2], tie;
    logic [3:0] op[2];
    logic [W-1:0] a[2], b[2];
    int g, q;
    #1;
    rv = '{rv0, rv1}; rr = '{rr0, rr1};
    op = '{op0, op1}; a = '{a0, a1}; b = '{b0, b1};
    for (int p = 0; p < 2; p++) begin
      ok[p] = !mv[p] || rr[p];
      el[p] = reset_n && rv[p] && ok[p];
    end
    g = -1;
    for (int p = 0; p < 2; p++) begin
      q = 1 - p;
      tie = FIXED ? (p == 0) : (prefer == p);
      rdy[p] = reset_n && ok[p] && (!el[q] || tie);
      if (el[p] && rdy[p]) g = p;
    end
    chk("req_ready0", ReqReady_0, rdy[0]);
    chk("req_ready1", ReqReady_1, rdy[1]);
    q = (g == 1) ? 1 : 0;
    chk("alu_op", AluOp, op[q]);
    chk("alu_a", AluA, a[q]);
    chk("alu_b", AluB, b[q]);
    @(posedge clk);
    if (!reset_n) model_reset();
    else begin
      for (int p = 0; p < 2; p++) begin
        if (g == p) begin
          mv[p] = 1;
          md[p] = alu_f(op[p], a[p], b[p]);
        end else if (rr[p]) mv[p] = 0;
      end
      if (g >= 0) prefer = 1 - g;
    end
    #1;
    chk("rsp_valid0", RspValid_0, mv[0]);
    chk("rsp_valid1", RspValid_1, mv[1]);
    chk("rsp_data0", RspData_0, md[0]);
    chk("rsp_data1", RspData_1, md[1]);
  endtask

  initial begin
    logic [W-1:0] exp_d;
    model_reset();
    reset_n = 0; rv0 = 0; rv1 = 0; rr0 = 1; rr1 = 1;
    op0 = ALU_ADD; op1 = ALU_AND; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    step(); step();
    chk("reset_valid0", RspValid_0, 1'b0);
    chk("reset_data1", RspData_1, 32'd0);

    reset_n = 1; rv0 = 1; op0 = ALU_ADD; a0 = 5; b0 = 7;
    step();
    chk("add_valid", RspValid_0, 1'b1);
    chk("add_data", RspData_0, 32'd12);
    rv0 = 0;
    step();
    chk("add_pulse", RspValid_0, 1'b0);

    reset_n = 0; step(); reset_n = 1;
    rv0 = 1; op0 = ALU_SUB; a0 = 10; b0 = 3;
    rv1 = 1; op1 = ALU_XOR; a1 = 32'hF0; b1 = 32'h0F;
    for (int i = 0; i < 6; i++) begin
      #1 chk("alt_grant0", ReqReady_0, FIXED ? 1'b1 : (i % 2 == 0));
      step();
    end
    chk("alt_data0", RspData_0, 32'd7);
    if (!FIXED) chk("alt_data1", RspData_1, 32'hFF);

    rr0 = 0; op0 = ALU_ADD; a0 = 1; b0 = 2; op1 = ALU_OR;
    step();
    for (int i = 0; i < 3; i++) begin
      a1 = $urandom; b1 = $urandom;
      #1 chk("blk_ready0", ReqReady_0, 1'b0);
      chk("blk_ready1", ReqReady_1, 1'b1);
      step();
    end
    rr0 = 1;
    #1 chk("release_ready0", ReqReady_0, 1'b1);
    step();

    rv1 = 0; rr0 = 1;
    for (int i = 0; i < 8; i++) begin
      op0 = 4'($urandom); a0 = $urandom; b0 = $urandom;
      exp_d = alu_f(op0, a0, b0);
      step();
      chk("b2b_valid", RspValid_0, 1'b1);
      chk("b2b_data", RspData_0, exp_d);
    end

    rv0 = 1; rv1 = 1; rr0 = 0; rr1 = 0;
    step(); step();
    chk("full0", RspValid_0, 1'b1);
    chk("full1", RspValid_1, 1'b1);
    reset_n = 0;
    step();
    chk("rst_clear0", RspValid_0, 1'b0);
    chk("rst_clear1", RspValid_1, 1'b0);
    reset_n = 1; rr0 = 1; rr1 = 1;
    #1 chk("rst_tie0", ReqReady_0, 1'b1);
    chk("rst_tie1", ReqReady_1, 1'b0);
    step();

    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 49) != 0);
      rv0 = $urandom_range(0, 3) != 0; rv1 = $urandom_range(0, 3) != 0;
      rr0 = $urandom_range(0, 9) < 7;  rr1 = $urandom_range(0, 9) < 7;
      op0 = 4'($urandom); op1 = 4'($urandom);
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      step();
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    reset_n = 1; rv0 = 1; rv1 = 1; rr0 = 1; rr1 = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("fixed_starve1", ReqReady_1, 1'b0);
      step();
    end
    rv0 = 0;
    #1 chk("fixed_take1", ReqReady_1, 1'b1);
    step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
